// File: rtl/clk_div_monitor.sv
`default_nettype none
// clk_div_monitor: samples a divided clock in the i_clk domain and measures its period and high time.
// It compares each measurement with the expected values and reports lock, error pulses, timeout and a sticky error.
module clk_div_monitor #(
   parameter int CNT_W       = 10,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_CNT    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_b,
   input  logic             i_en,
   input  logic             i_div_clk,
   input  logic [CNT_W-1:0] i_exp_period,
   input  logic [CNT_W-1:0] i_exp_high,
   input  logic             i_err_clr,
   output logic             o_meas_valid,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_err_period,
   output logic             o_err_duty,
   output logic             o_timeout,
   output logic             o_locked,
   output logic             o_err_sticky
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s, s_d, rise, fall;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [CNT_W-1:0]       high_cap, high_cap_nxt;
   logic [CNT_W-1:0]       meas_high, high_diff;
   logic [3:0]             good_cnt, good_cnt_nxt;
   logic                   complete, timeout_nxt, err_p, err_d;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      high_cap_nxt = high_cap;
      meas_high    = high_cap;
      complete     = 1'b0;
      timeout_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt      = '0;
            high_cap_nxt = '0;
            if (i_en) state_nxt = SEEK;
         end
         SEEK: begin
            if (rise) begin
               state_nxt = HIGH;
               cnt_nxt   = CNT_ONE;
            end
         end
         HIGH, LOW: begin
            if (cnt == CNT_MAX) begin
               timeout_nxt = 1'b1;
               state_nxt   = SEEK;
               cnt_nxt     = '0;
            end else if (rise) begin
               // a rise while still HIGH is an implied fall then rise
               complete  = 1'b1;
               meas_high = (state == HIGH) ? cnt : high_cap;
               state_nxt = HIGH;
               cnt_nxt   = CNT_ONE;
            end else begin
               // the fall cycle still counts so the period stays exact
               cnt_nxt = cnt + 1'b1;
               if (fall && state == HIGH) begin
                  high_cap_nxt = cnt;
                  state_nxt    = LOW;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!i_en) begin
         state_nxt   = IDLE;
         cnt_nxt     = '0;
         complete    = 1'b0;
         timeout_nxt = 1'b0;
      end
   end

   always_comb begin
      high_diff = (meas_high >= i_exp_high) ? (meas_high - i_exp_high)
                                            : (i_exp_high - meas_high);
      err_p     = (cnt != i_exp_period);
      err_d     = (high_diff > CNT_ONE);
   end

   always_comb begin
      good_cnt_nxt = good_cnt;
      if (!i_en || timeout_nxt) begin
         good_cnt_nxt = '0;
      end else if (complete) begin
         if (err_p || err_d)         good_cnt_nxt = '0;
         else if (good_cnt != LOCK_TGT) good_cnt_nxt = good_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         sync_q       <= '0;
         s_d          <= 1'b0;
         state        <= IDLE;
         cnt          <= '0;
         high_cap     <= '0;
         good_cnt     <= '0;
         o_meas_valid <= 1'b0;
         o_period     <= '0;
         o_high       <= '0;
         o_err_period <= 1'b0;
         o_err_duty   <= 1'b0;
         o_timeout    <= 1'b0;
         o_err_sticky <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], i_div_clk};
         s_d          <= s;
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         high_cap     <= high_cap_nxt;
         good_cnt     <= good_cnt_nxt;
         o_meas_valid <= complete;
         o_err_period <= complete & err_p;
         o_err_duty   <= complete & err_d;
         o_timeout    <= timeout_nxt;
         if (complete) begin
            o_period <= cnt;
            o_high   <= meas_high;
         end
         if (o_err_period || o_err_duty || o_timeout) o_err_sticky <= 1'b1;
         else if (i_err_clr)                         o_err_sticky <= 1'b0;
      end
   end

   assign o_locked = (good_cnt == LOCK_TGT);

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// tb_clk_div_monitor: directed self-checking bench for clk_div_monitor with a half-cycle pattern source.
module tb_clk_div_monitor;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       en = 1'b0;
   logic       div_clk = 1'b0;
   logic [9:0] exp_period = 10'd5;
   logic [9:0] exp_high = 10'd2;
   logic       err_clr = 1'b0;
   logic       meas_valid, err_period, err_duty, timeout, locked, err_sticky;
   logic [9:0] period, high;

   int passed = 0;
   int total = 0;

   // pattern source: period and high time in half-cycles of clk
   int gen_ph = 8;
   int gen_hh = 4;
   bit gen_run = 1'b0;
   int hc = 0;
   int cyc = 0;
   int last_rise_cyc = 0;

   clk_div_monitor #(.CNT_W(10), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
      .i_clk        (clk),
      .i_rst_b      (rst_b),
      .i_en         (en),
      .i_div_clk    (div_clk),
      .i_exp_period (exp_period),
      .i_exp_high   (exp_high),
      .i_err_clr    (err_clr),
      .o_meas_valid (meas_valid),
      .o_period     (period),
      .o_high       (high),
      .o_err_period (err_period),
      .o_err_duty   (err_duty),
      .o_timeout    (timeout),
      .o_locked     (locked),
      .o_err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(clk) begin
      logic prev;
      #1;
      prev = div_clk;
      if (!gen_run) begin
         div_clk = 1'b0;
         hc = 0;
      end else begin
         div_clk = (hc < gen_hh);
         hc = (hc + 1) % gen_ph;
      end
      if (!prev && div_clk) last_rise_cyc = cyc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (meas_valid !== 1'b1 && n < 60);
      check({tag, " valid"}, 32'(meas_valid), 32'd1);
   endtask

   task automatic start_pattern(input int ph, input int hh, input logic [9:0] ep, input logic [9:0] eh);
      gen_run = 1'b0;
      en = 1'b0;
      repeat (4) @(negedge clk);
      gen_ph = ph;
      gen_hh = hh;
      exp_period = ep;
      exp_high = eh;
      gen_run = 1'b1;
      en = 1'b1;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst valid", 32'(meas_valid), 0);
      check("rst period", 32'(period), 0);
      check("rst high", 32'(high), 0);
      check("rst err_period", 32'(err_period), 0);
      check("rst err_duty", 32'(err_duty), 0);
      check("rst timeout", 32'(timeout), 0);
      check("rst locked", 32'(locked), 0);
      check("rst sticky", 32'(err_sticky), 0);
      rst_b = 1'b1;

      // divide-by-5, 50% duty: period 5, high 2 or 3 depending on phase
      start_pattern(10, 5, 10'd5, 10'd2);
      for (int i = 1; i <= 6; i++) begin
         wait_valid("div5");
         check("div5 period", 32'(period), 5);
         check("div5 high", 32'(high == 10'd2 || high == 10'd3), 1);
         check("div5 err_period", 32'(err_period), 0);
         check("div5 err_duty", 32'(err_duty), 0);
         check("div5 locked", 32'(locked), 32'(i >= 4));
      end
      check("div5 sticky", 32'(err_sticky), 0);

      // 7-cycle period, 6 high
      start_pattern(14, 12, 10'd7, 10'd6);
      for (int i = 1; i <= 5; i++) begin
         wait_valid("p7h6");
         check("p7h6 period", 32'(period), 7);
         check("p7h6 high", 32'(high), 6);
         check("p7h6 locked", 32'(locked), 32'(i >= 4));
      end

      // duty error with clear in the same cycle, then clear alone
      exp_high = 10'd3;
      wait_valid("duty");
      check("duty err_duty", 32'(err_duty), 1);
      check("duty err_period", 32'(err_period), 0);
      check("duty locked", 32'(locked), 0);
      err_clr = 1'b1;
      @(negedge clk);
      check("collide sticky", 32'(err_sticky), 1);
      @(negedge clk);
      check("clear sticky", 32'(err_sticky), 0);
      err_clr = 1'b0;
      exp_high = 10'd6;

      // period mismatch, then corrected expectation relocks
      start_pattern(10, 5, 10'd6, 10'd2);
      for (int i = 1; i <= 3; i++) begin
         wait_valid("mism");
         check("mism err_period", 32'(err_period), 1);
         check("mism locked", 32'(locked), 0);
         if (i >= 2) check("mism sticky", 32'(err_sticky), 1);
      end
      exp_period = 10'd5;
      for (int i = 1; i <= 4; i++) begin
         wait_valid("fixed");
         check("fixed err_period", 32'(err_period), 0);
         check("fixed locked", 32'(locked), 32'(i == 4));
      end

      // disable mid-period: outputs hold, lock and pulses clear
      start_pattern(14, 12, 10'd7, 10'd6);
      for (int i = 1; i <= 4; i++) wait_valid("pre-dis");
      check("pre-dis locked", 32'(locked), 1);
      repeat (2) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("dis locked", 32'(locked), 0);
      check("dis valid", 32'(meas_valid), 0);
      check("dis period", 32'(period), 7);
      check("dis high", 32'(high), 6);
      check("dis sticky", 32'(err_sticky), 1);
      repeat (5) @(negedge clk);
      en = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (meas_valid !== 1'b1 && n < 60);
      check("reen valid", 32'(meas_valid), 1);
      // two full rises 7 cycles apart are needed before the first result
      check("reen latency", 32'(n >= 8), 1);
      check("reen period", 32'(period), 7);
      check("reen high", 32'(high), 6);

      // stuck input: timeout 1023 cycles after the last detected rise
      start_pattern(8, 4, 10'd4, 10'd2);
      for (int i = 1; i <= 4; i++) wait_valid("div4");
      check("div4 locked", 32'(locked), 1);
      gen_run = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (timeout !== 1'b1 && n < 1100);
      check("stuck timeout", 32'(timeout), 1);
      check("stuck locked", 32'(locked), 0);
      // 1 cycle to sample + 2 sync stages + 1023 counter cycles
      check("stuck delay", 32'(cyc - last_rise_cyc), 1026);
      @(negedge clk);
      check("stuck pulse width", 32'(timeout), 0);
      check("stuck sticky", 32'(err_sticky), 1);
      gen_run = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wait_valid("relock");
         check("relock period", 32'(period), 4);
         check("relock locked", 32'(locked), 32'(i == 4));
      end

      // asynchronous reset mid-period
      repeat (2) @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      check("arst period", 32'(period), 0);
      check("arst high", 32'(high), 0);
      check("arst locked", 32'(locked), 0);
      check("arst sticky", 32'(err_sticky), 0);
      check("arst valid", 32'(meas_valid), 0);
      @(negedge clk);
      rst_b = 1'b1;
      gen_run = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
